demux_1_2: RTL
==============

DEMUX_1_2 -- requirements
Module: demux_1_2

Interface
REQ-001 SHALL provide parameter: WIDTH, default 8, data width in bits.
REQ-002 SHALL provide port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL provide port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port: in_data  input  WIDTH  input beat payload.
REQ-005 SHALL provide port: in_last  input  1  final beat of packet.
REQ-006 SHALL provide port: in_sel  input  1  destination (0 = out0, 1 = out1), sampled on first beat only.
REQ-007 SHALL provide port: in_valid  input  1  input beat present.
REQ-008 SHALL provide port: in_ready  output  1  input beat accepted when in_valid & in_ready.
REQ-009 SHALL provide ports: out0_data  output  WIDTH; out0_last  output  1; out0_valid  output  1; out0_ready  input  1 -- destination 0 stream.
REQ-010 SHALL provide ports: out1_data  output  WIDTH; out1_last  output  1; out1_valid  output  1; out1_ready  input  1 -- destination 1 stream.
REQ-011 SHALL provide, only with DEMUX_CNT_EN: cnt_clr  input  1  sync counter clear; cnt0, cnt1  output  16  accepted-beat counts per destination.

Function
REQ-012 SHALL implement FSM states IDLE, LOCK0, LOCK1.
REQ-013 SHALL target out[in_sel] in IDLE; out0 in LOCK0; out1 in LOCK1; in_sel ignored in LOCK states.
REQ-014 SHALL, on accepted beat in IDLE with in_last=0, move to LOCK[in_sel]; with in_last=1, stay IDLE (single-beat packet).
REQ-015 SHALL, on accepted beat in LOCKn with in_last=1, return to IDLE; otherwise hold LOCKn.
REQ-016 SHALL hold one output register stage per destination (data, last, valid).
REQ-017 SHALL drive in_ready = ~outT_valid | outT_ready, T = current target; combinational, no dependency on in_valid.
REQ-018 SHALL present an accepted beat on target outputs exactly one cycle after acceptance; sustained throughput one beat per clk.
REQ-019 SHALL keep outN_valid/data/last stable while outN_valid=1 and outN_ready=0.
REQ-020 SHALL clear outN_valid when outN_ready=1 and no new beat is loaded into N that cycle; same-cycle drain and load SHALL replace contents, valid stays 1.
REQ-021 SHALL let the non-target destination drain independently; its stall SHALL NOT affect in_ready.
REQ-022 SHALL never duplicate, drop or reorder beats; packets never split across destinations.

Reset
REQ-023 SHALL, on rst_n low, asynchronously force state IDLE, out0_valid=out1_valid=0, outN_data=0, outN_last=0, cnt0=cnt1=0.
REQ-024 SHALL discard a packet in progress when reset asserts mid-packet; first beat after release is treated as a new packet header.
REQ-025 SHALL hold in_ready = 1 after reset release (both output registers empty).

Configuration
REQ-026 SHALL, with macro DEMUX_CNT_EN defined, include cnt_clr/cnt0/cnt1; cntN increments by 1 per beat accepted into destination N, wraps 0xFFFF -> 0x0000.
REQ-027 SHALL give cnt_clr priority: clear and increment in same cycle yields 0.
REQ-028 SHALL, without DEMUX_CNT_EN, omit those ports and counter logic; datapath behaviour identical.

Verification
REQ-029 SHALL cover: reset, single beat in_data=0xA5, in_sel=1, in_last=1, out1_ready=1 -> next cycle out1_valid=1, out1_data=0xA5, out1_last=1, out0_valid=0, state IDLE.
REQ-030 SHALL cover: 3-beat packet 0x11,0x22,0x33 with in_sel=0 on beat 1, in_sel=1 on beats 2-3 -> all three on out0 in order, out1_valid never 1.
REQ-031 SHALL cover: out0_ready=0, two beats to out0 -> first held on out0, in_ready=0 on second; out0_ready=1 -> out0 drains, second beat accepted same cycle.
REQ-032 SHALL cover: out0 stalled full, new packet in_sel=1 -> in_ready=1, beat delivered on out1 while out0 holds value.
REQ-033 SHALL cover: rst_n low mid-packet in LOCK1 -> all valids 0 immediately; next beat with in_sel=0 routes to out0.
REQ-034 SHALL cover (DEMUX_CNT_EN): 0xFFFF beats to out1 then one more -> cnt1 = 0; cnt_clr with accepted beat -> cnt0 = 0.

Source files
------------

// File: rtl/demux_1_2.sv
// 1-to-2 packet demultiplexer with one output register stage per destination.
// Optional per-destination accepted-beat counters are built when DEMUX_CNT_EN is defined.
module demux_1_2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out0_data,
    output logic             out0_last,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out1_last,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_CNT_EN
    ,
    input  logic             cnt_clr,
    output logic [15:0]      cnt0,
    output logic [15:0]      cnt1
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic       w_tgt;
    logic       w_in_ready;
    logic       w_accept;
    logic [1:0] w_out_ready;
    logic [1:0] w_out_valid;
    logic [1:0] w_out_last;
    logic [1:0] w_load;
    logic [WIDTH-1:0] w_out_data [2];
`ifdef DEMUX_CNT_EN
    logic [15:0] w_cnt [2];
`endif

    assign w_out_ready[0] = out0_ready;
    assign w_out_ready[1] = out1_ready;

    // The header beat picks the destination; body beats follow the locked one.
    always_comb begin
        w_tgt = in_sel;
        case (r_state)
            IDLE:    w_tgt = in_sel;
            LOCK0:   w_tgt = 1'b0;
            LOCK1:   w_tgt = 1'b1;
            default: w_tgt = in_sel;
        endcase
    end

    assign w_in_ready = ~w_out_valid[w_tgt] | w_out_ready[w_tgt];
    assign w_accept   = in_valid & w_in_ready;
    assign in_ready   = w_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept && !in_last) begin
                    w_state_next = in_sel ? LOCK1 : LOCK0;
                end
            end
            LOCK0, LOCK1: begin
                if (w_accept && in_last) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_dst
            logic             r_valid;
            logic             r_last;
            logic [WIDTH-1:0] r_data;

            assign w_load[gi] = w_accept & (w_tgt == (gi == 1));

            // A load wins over a drain, so a same-cycle drain+load keeps valid high.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid <= 1'b0;
                    r_last  <= 1'b0;
                    r_data  <= '0;
                end else if (w_load[gi]) begin
                    r_valid <= 1'b1;
                    r_last  <= in_last;
                    r_data  <= in_data;
                end else if (w_out_ready[gi]) begin
                    r_valid <= 1'b0;
                end
            end

            assign w_out_valid[gi] = r_valid;
            assign w_out_last[gi]  = r_last;
            assign w_out_data[gi]  = r_data;

`ifdef DEMUX_CNT_EN
            logic [15:0] r_cnt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= 16'd0;
                end else if (cnt_clr) begin
                    r_cnt <= 16'd0;
                end else if (w_load[gi]) begin
                    r_cnt <= r_cnt + 16'd1;
                end
            end

            assign w_cnt[gi] = r_cnt;
`endif
        end
    endgenerate

    assign out0_data  = w_out_data[0];
    assign out0_last  = w_out_last[0];
    assign out0_valid = w_out_valid[0];
    assign out1_data  = w_out_data[1];
    assign out1_last  = w_out_last[1];
    assign out1_valid = w_out_valid[1];

`ifdef DEMUX_CNT_EN
    assign cnt0 = w_cnt[0];
    assign cnt1 = w_cnt[1];
`endif

endmodule
